// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receiver.
//   - scan-code prefix bytes (extended, break)
//   - frame FSM state encoding
//   - frame length in bits (start + 8 data + parity + stop)
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam int FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: deframes 11-bit PS/2 device-to-host frames into bytes.
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high
//   ps2_clk     in   PS/2 clock from device (asynchronous)
//   ps2_dat     in   PS/2 data from device (asynchronous)
//   byte_data   out  last correctly received byte (held between pulses)
//   byte_valid  out  one-cycle pulse, byte_data updated
//   parity_err  out  one-cycle pulse, frame failed odd parity
//   frame_err   out  one-cycle pulse, bad start/stop bit or mid-frame timeout
//
// Handshake: byte_valid, parity_err and frame_err are single-cycle strobes
// with no back-pressure; the consumer must sample them on the cycle they
// are high. At most one of them is high in any cycle.
//
// The frame FSM state is held in the 'state' signal for observation.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DATA_BITS = FRAME_BITS - 3;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   sync_clk_prev;
  logic                   sync_clk;
  logic                   sync_dat;
  logic                   fall;

  frame_state_e state, state_d;
  logic [2:0]       bit_cnt, bit_cnt_d;
  logic [7:0]       shift, shift_d;
  logic             par, par_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [7:0]       byte_data_d;
  logic             byte_valid_d;
  logic             parity_err_d;
  logic             frame_err_d;

  assign sync_clk = clk_sync[SYNC_STAGES-1];
  assign sync_dat = dat_sync[SYNC_STAGES-1];
  assign fall     = sync_clk_prev & ~sync_clk;

  // State register, synchronizers and registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync      <= '1;
      dat_sync      <= '1;
      sync_clk_prev <= 1'b1;
      state         <= IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      par           <= 1'b0;
      cnt           <= '0;
      byte_data     <= '0;
      byte_valid    <= 1'b0;
      parity_err    <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      clk_sync[0] <= ps2_clk;
      dat_sync[0] <= ps2_dat;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_sync[i] <= clk_sync[i-1];
        dat_sync[i] <= dat_sync[i-1];
      end
      sync_clk_prev <= sync_clk;
      state         <= state_d;
      bit_cnt       <= bit_cnt_d;
      shift         <= shift_d;
      par           <= par_d;
      cnt           <= cnt_d;
      byte_data     <= byte_data_d;
      byte_valid    <= byte_valid_d;
      parity_err    <= parity_err_d;
      frame_err     <= frame_err_d;
    end
  end

  // Next-state and strobe logic.
  always_comb begin
    state_d      = state;
    bit_cnt_d    = bit_cnt;
    shift_d      = shift;
    par_d        = par;
    byte_data_d  = byte_data;
    byte_valid_d = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    if (fall || state == IDLE) cnt_d = '0;
    else                       cnt_d = cnt + CNT_W'(1);

    if (fall) begin
      case (state)
        IDLE: begin
          if (!sync_dat) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;  // start bit must be 0
          end
        end
        DATA: begin
          // LSB arrives first, so shift in from the top.
          shift_d   = {sync_dat, shift[7:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'(DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          par_d   = sync_dat;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!sync_dat) begin
            frame_err_d = 1'b1;
          end else if (((^shift) ^ par) == 1'b0) begin
            parity_err_d = 1'b1;  // odd parity: data plus parity must XOR to 1
          end else begin
            byte_data_d  = shift;
            byte_valid_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state != IDLE && cnt == CNT_W'(TIMEOUT_CYCLES)) begin
      // Only reachable without an edge this cycle, so an edge always wins.
      state_d     = IDLE;
      frame_err_d = 1'b1;
      cnt_d       = '0;
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: host-side PS/2 keyboard receiver. Deframes bytes with
// ps2_frame_rx and folds the 0xE0 (extended) and 0xF0 (break) prefixes into
// one key event per keystroke.
//
// Ports:
//   CLOCK_50      in   system clock, 50 MHz
//   reset         in   synchronous, active-high
//   ps2_clk       in   PS/2 clock from device (asynchronous, never driven)
//   ps2_dat       in   PS/2 data from device (asynchronous, never driven)
//   byte_data     out  last correctly received byte
//   byte_valid    out  one-cycle pulse, byte_data updated
//   parity_err    out  one-cycle pulse, frame had bad odd parity
//   frame_err     out  one-cycle pulse, bad start/stop bit or timeout
//   key_code      out  scan code of last key event
//   key_extended  out  event was prefixed by 0xE0
//   key_released  out  event was prefixed by 0xF0
//   key_valid     out  one-cycle pulse, key_* fields updated
//
// Handshake: all *_valid / *_err outputs are single-cycle strobes with no
// ready; key_valid follows the causing byte_valid by exactly one cycle.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       key_valid
);

  logic ext_flag;
  logic brk_flag;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_frame_rx (
    .clk        (CLOCK_50),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  // Prefix decoder. A corrupted frame drops any pending prefixes so a
  // damaged sequence cannot produce a mislabeled key.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ext_flag     <= 1'b0;
      brk_flag     <= 1'b0;
      key_code     <= '0;
      key_extended <= 1'b0;
      key_released <= 1'b0;
      key_valid    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (parity_err || frame_err) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (byte_valid) begin
        if (byte_data == PS2_PREFIX_EXT) begin
          ext_flag <= 1'b1;
        end else if (byte_data == PS2_PREFIX_BRK) begin
          brk_flag <= 1'b1;
        end else begin
          key_code     <= byte_data;
          key_extended <= ext_flag;
          key_released <= brk_flag;
          key_valid    <= 1'b1;
          ext_flag     <= 1'b0;
          brk_flag     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: directed bench for ps2_keyboard_rx.
module tb_ps2_keyboard_rx;
  import ps2_pkg::*;

  localparam int TIMEOUT_CYCLES = 5000;
  localparam int SYNC_STAGES    = 2;
  localparam int HALF           = 10;  // system cycles per PS/2 clock half period

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_dat  = 1'b1;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       parity_err;
  logic       frame_err;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_released;
  logic       key_valid;

  ps2_keyboard_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_dat      (ps2_dat),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .key_code     (key_code),
    .key_extended (key_extended),
    .key_released (key_released),
    .key_valid    (key_valid)
  );

  // ---------------- clock / reset ----------------
  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];  // bytes expected on byte_valid, in order
  int   bv_cnt = 0, kv_cnt = 0, pe_cnt = 0, fe_cnt = 0;
  int   s_bv, s_kv, s_pe, s_fe;
  int   fe_cyc = 0, fall_cyc = 0;
  logic prev_bv = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (byte_valid) begin
        bv_cnt++;
        if (exp_q.size() == 0) check("byte_unexpected_q_size", 32'(exp_q.size()), 32'd1);
        else                   check("byte_data", {24'd0, byte_data}, {24'd0, exp_q.pop_front()});
      end
      if (key_valid) begin
        kv_cnt++;
        check("key_valid_follows_byte_valid", {31'd0, prev_bv}, 32'd1);
      end
      if (parity_err) pe_cnt++;
      if (frame_err) begin
        fe_cnt++;
        fe_cyc = cyc;
      end
    end
    prev_bv = byte_valid;
  end

  // ---------------- driver tasks ----------------
  // Sends the first nedges bits of a frame; data changes while ps2_clk is
  // high, the host samples on the falling edge.
  task automatic send_frame(input logic [7:0] d, input logic bad_par,
                            input logic stop, input int nedges);
    logic [FRAME_BITS-1:0] f;
    f = {stop, (~^d) ^ bad_par, d, 1'b0};
    if (nedges == FRAME_BITS && stop && !bad_par) exp_q.push_back(d);
    for (int i = 0; i < nedges; i++) begin
      @(negedge CLOCK_50);
      ps2_dat = f[i];
      repeat (HALF) @(negedge CLOCK_50);
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      repeat (HALF) @(negedge CLOCK_50);
      ps2_clk = 1'b1;
    end
    @(negedge CLOCK_50);
    ps2_dat = 1'b1;
    repeat (40) @(negedge CLOCK_50);
  endtask

  task automatic snap();
    s_bv = bv_cnt; s_kv = kv_cnt; s_pe = pe_cnt; s_fe = fe_cnt;
  endtask

  task automatic expect_counts(input string tag, input int dbv, input int dkv,
                               input int dpe, input int dfe);
    check({tag, "_byte_valid_count"}, 32'(bv_cnt - s_bv), 32'(dbv));
    check({tag, "_key_valid_count"},  32'(kv_cnt - s_kv), 32'(dkv));
    check({tag, "_parity_err_count"}, 32'(pe_cnt - s_pe), 32'(dpe));
    check({tag, "_frame_err_count"},  32'(fe_cnt - s_fe), 32'(dfe));
    check({tag, "_exp_q_drained"},    32'(exp_q.size()), 32'd0);
  endtask

  task automatic expect_key(input string tag, input logic [7:0] code,
                            input logic ext, input logic rel);
    check({tag, "_key_code"},     {24'd0, key_code},     {24'd0, code});
    check({tag, "_key_extended"}, {31'd0, key_extended}, {31'd0, ext});
    check({tag, "_key_released"}, {31'd0, key_released}, {31'd0, rel});
  endtask

  task automatic expect_all_zero(input string tag);
    check({tag, "_byte_data"},  {24'd0, byte_data}, 32'd0);
    check({tag, "_byte_valid"}, {31'd0, byte_valid}, 32'd0);
    check({tag, "_parity_err"}, {31'd0, parity_err}, 32'd0);
    check({tag, "_frame_err"},  {31'd0, frame_err}, 32'd0);
    check({tag, "_key_valid"},  {31'd0, key_valid}, 32'd0);
    expect_key(tag, 8'h00, 1'b0, 1'b0);
    check({tag, "_fsm_idle"}, 32'(dut.u_frame_rx.state), 32'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (5) @(negedge CLOCK_50);
    expect_all_zero("reset");
    reset = 1'b0;
    repeat (5) @(negedge CLOCK_50);

    // Plain make code.
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, FRAME_BITS);
    expect_counts("make_1c", 1, 1, 0, 0);
    expect_key("make_1c", 8'h1C, 1'b0, 1'b0);

    // Break code.
    snap();
    send_frame(8'hF0, 1'b0, 1'b1, FRAME_BITS);
    send_frame(8'h1C, 1'b0, 1'b1, FRAME_BITS);
    expect_counts("break_1c", 2, 1, 0, 0);
    expect_key("break_1c", 8'h1C, 1'b0, 1'b1);

    // Extended break, then a plain make clears both flags.
    snap();
    send_frame(8'hE0, 1'b0, 1'b1, FRAME_BITS);
    send_frame(8'hF0, 1'b0, 1'b1, FRAME_BITS);
    send_frame(8'h75, 1'b0, 1'b1, FRAME_BITS);
    expect_counts("ext_break_75", 3, 1, 0, 0);
    expect_key("ext_break_75", 8'h75, 1'b1, 1'b1);
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, FRAME_BITS);
    expect_counts("after_ext_1c", 1, 1, 0, 0);
    expect_key("after_ext_1c", 8'h1C, 1'b0, 1'b0);

    // Repeated prefix is idempotent.
    snap();
    send_frame(8'hE0, 1'b0, 1'b1, FRAME_BITS);
    send_frame(8'hE0, 1'b0, 1'b1, FRAME_BITS);
    send_frame(8'h6B, 1'b0, 1'b1, FRAME_BITS);
    expect_counts("ext_twice_6b", 3, 1, 0, 0);
    expect_key("ext_twice_6b", 8'h6B, 1'b1, 1'b0);

    // Parity error drops the pending prefix; byte_data keeps last good byte.
    snap();
    send_frame(8'hE0, 1'b0, 1'b1, FRAME_BITS);
    send_frame(8'h1C, 1'b1, 1'b1, FRAME_BITS);
    expect_counts("parity_bad", 1, 0, 1, 0);
    check("parity_bad_byte_data_held", {24'd0, byte_data}, 32'hE0);
    snap();
    send_frame(8'h74, 1'b0, 1'b1, FRAME_BITS);
    expect_counts("after_parity_74", 1, 1, 0, 0);
    expect_key("after_parity_74", 8'h74, 1'b0, 1'b0);

    // Bad stop bit: frame_err, prefix dropped.
    snap();
    send_frame(8'hF0, 1'b0, 1'b1, FRAME_BITS);
    send_frame(8'h2B, 1'b0, 1'b0, FRAME_BITS);
    expect_counts("stop_bad", 1, 0, 0, 1);
    snap();
    send_frame(8'h2B, 1'b0, 1'b1, FRAME_BITS);
    expect_counts("after_stop_2b", 1, 1, 0, 0);
    expect_key("after_stop_2b", 8'h2B, 1'b0, 1'b0);

    // Timeout: start bit plus 4 data bits, then the line idles.
    snap();
    send_frame(8'h0F, 1'b0, 1'b1, 5);
    for (int n = 0; n < TIMEOUT_CYCLES + 1000 && fe_cnt == s_fe; n++) @(negedge CLOCK_50);
    expect_counts("timeout", 0, 0, 0, 1);
    check("timeout_latency", 32'(fe_cyc - fall_cyc), 32'(TIMEOUT_CYCLES + SYNC_STAGES + 2));
    check("timeout_fsm_idle", 32'(dut.u_frame_rx.state), 32'(IDLE));
    snap();
    send_frame(8'h29, 1'b0, 1'b1, FRAME_BITS);
    expect_counts("after_timeout_29", 1, 1, 0, 0);
    expect_key("after_timeout_29", 8'h29, 1'b0, 1'b0);

    // Reset mid-frame after a pending prefix.
    snap();
    send_frame(8'hE0, 1'b0, 1'b1, FRAME_BITS);
    send_frame(8'h5A, 1'b0, 1'b1, 6);
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    expect_all_zero("mid_frame_reset");
    reset = 1'b0;
    repeat (20) @(negedge CLOCK_50);
    expect_counts("mid_frame_reset", 1, 0, 0, 0);
    snap();
    send_frame(8'h5A, 1'b0, 1'b1, FRAME_BITS);
    expect_counts("after_reset_5a", 1, 1, 0, 0);
    expect_key("after_reset_5a", 8'h5A, 1'b0, 1'b0);
    check("after_reset_byte_data", {24'd0, byte_data}, 32'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
